// File: rtl/storage_uart_sender.sv
// Drains the storage byte FIFO through its read-enable/valid handshake and
// serialises each byte as an 8N1 UART frame, LSB first, in the ReadClock domain.
module storage_uart_sender #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter int unsigned VALID_TIMEOUT = 15,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                   ReadClock,
  input  logic                   Reset,
  input  logic [7:0]             DataIn,
  input  logic                   DataValid,
  input  logic                   DataReadyToSend,
  output logic                   ReadEnable,
  input  logic                   ClearToSend,
  input  logic                   TxEnable,
  output logic                   Tx,
  output logic                   Busy,
  output logic [COUNT_WIDTH-1:0] BytesSent,
  output logic                   Underflow
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TO_W   = $clog2(VALID_TIMEOUT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(VALID_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_VALID,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baudCnt;
  logic [TO_W-1:0]   timeoutCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic              goAhead;
  logic              bitDone;

  assign goAhead    = TxEnable & DataReadyToSend & ClearToSend;
  assign bitDone    = (baudCnt == BAUD_LAST);
  assign ReadEnable = (state == FETCH);
  assign Busy       = (state != IDLE);

  // Tx is loaded on the edge that enters each bit so it is valid from that
  // state's first cycle; FETCH and WAIT_VALID keep the idle/stop level.
  always_ff @(posedge ReadClock) begin
    if (Reset) begin
      state      <= IDLE;
      Tx         <= 1'b1;
      BytesSent  <= '0;
      Underflow  <= 1'b0;
      baudCnt    <= '0;
      timeoutCnt <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
    end else begin
      Underflow <= 1'b0;
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (goAhead) state <= FETCH;
        end
        FETCH: begin
          timeoutCnt <= '0;
          state      <= WAIT_VALID;
        end
        WAIT_VALID: begin
          if (DataValid) begin
            shiftReg <= DataIn;
            baudCnt  <= '0;
            Tx       <= 1'b0;
            state    <= START;
          end else if (timeoutCnt == TO_LAST) begin
            Underflow <= 1'b1;
            state     <= IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        START: begin
          if (bitDone) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            Tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitDone) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              Tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              Tx     <= shiftReg[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (bitDone) begin
            baudCnt   <= '0;
            BytesSent <= BytesSent + 1'b1;
            state     <= goAhead ? FETCH : IDLE;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: begin
          Tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/storage_uart_sender.md
Name: storage_uart_sender

Overview:
Downstream consumer of the DataStorage byte FIFO, in the ReadClock domain. It pulls bytes one at a time through the FIFO's read-enable/valid handshake and serialises each onto a UART TX line as 8N1, LSB first. It honours host flow control and a software transmit enable. It reports busy status, a sent-byte count and a read-underflow event.

Parameters:
CLKS_PER_BIT, 868, ReadClock cycles per UART bit (minimum 2).
VALID_TIMEOUT, 15, cycles to wait for DataValid after a read strobe before declaring underflow (minimum 1).
COUNT_WIDTH, 16, width of BytesSent.

Ports:
ReadClock  input  1  single block clock, rising edge.
Reset  input  1  synchronous reset, active-high.
DataIn  input  8  byte from the storage FIFO dout.
DataValid  input  1  FIFO valid: DataIn holds the byte read by the previous ReadEnable.
DataReadyToSend  input  1  storage FIFO not empty.
ReadEnable  output  1  one-cycle FIFO read strobe.
ClearToSend  input  1  host flow control, high = host may receive.
TxEnable  input  1  software enable for transmission.
Tx  output  1  UART serial out, idle high.
Busy  output  1  high whenever state != IDLE.
BytesSent  output  COUNT_WIDTH  count of completed frames, wraps.
Underflow  output  1  one-cycle pulse on read timeout.

Behaviour:
- Interface: one clock, ReadClock. Reset is synchronous and active-high.
- Reset values: Tx=1, ReadEnable=0, Busy=0, BytesSent=0, Underflow=0. State=IDLE and all counters cleared.
- States: IDLE, FETCH, WAIT_VALID, START, DATA, STOP.
- IDLE:
  - Go to FETCH when TxEnable & DataReadyToSend & ClearToSend are all high on a clock edge.
  - Otherwise stay in IDLE with Tx=1.
- FETCH:
  - ReadEnable=1 for exactly this one cycle. ReadEnable is combinational from state==FETCH.
  - Always go to WAIT_VALID next.
- WAIT_VALID:
  - On the first cycle with DataValid=1, latch DataIn into the shift register and go to START.
  - A timeout counter starts at 0 on entry and increments each cycle without DataValid.
  - When VALID_TIMEOUT cycles elapse with no DataValid: Underflow=1 for one cycle, go to IDLE, no frame sent.
- DataValid in any state other than WAIT_VALID is ignored. No latch, no error.
- START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - Tx=shift[bit index] for CLKS_PER_BIT cycles per bit, LSB first.
  - After bit 7, go to STOP.
- STOP: Tx=1 for CLKS_PER_BIT cycles. On the final cycle:
  - BytesSent increments, modulo 2^COUNT_WIDTH; all-ones wraps to 0.
  - If TxEnable & DataReadyToSend & ClearToSend, go straight to FETCH (back-to-back).
  - Otherwise go to IDLE.
- Tx is registered and valid from the first cycle of each state. The baud counter reloads on every bit boundary.
- Latency, with FIFO valid one cycle after the read strobe:
  - Conditions true at edge N.
  - ReadEnable high in cycle N+1.
  - DataValid in cycle N+2.
  - Tx low from cycle N+3.
  - One frame occupies exactly 10*CLKS_PER_BIT cycles of START+DATA+STOP.
- Back-to-back frames are separated by the FETCH and WAIT_VALID cycles, at least 2 cycles, with Tx held high.
- A ClearToSend or TxEnable drop mid-frame does not abort. The current frame completes, then the block returns to IDLE.
- DataReadyToSend is sampled only in IDLE and at the end of STOP.
- Reset asserted mid-frame: at the next edge Tx=1 and state=IDLE. The partial byte is lost and BytesSent=0.
- Exactly one ReadEnable pulse is issued per transmitted byte or underflow. It is never issued outside FETCH.

Test Plan:
- Single byte (CLKS_PER_BIT=4, TxEnable=CTS=1): FIFO holds 0xA5.
  - Required: ReadEnable pulses once, then Tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Required: Tx falls 3 cycles after the conditions are sampled; BytesSent=1; Busy low after STOP.
- Back-to-back: FIFO holds 0xFF, 0x80, 0x7F.
  - Required: three frames with correct bit patterns, exactly 3 ReadEnable pulses, BytesSent=3.
  - Required: Tx high during every inter-frame gap, gap ≥2 cycles.
- Underflow (VALID_TIMEOUT=15): DataReadyToSend=1 but DataValid never asserts.
  - Required: Underflow pulses 1 cycle, 16 cycles after ReadEnable; state returns to IDLE.
  - Required: Tx stays 1 and BytesSent is unchanged.
- Flow control: CTS=0 with data pending → no ReadEnable and Tx=1 indefinitely.
  - Drop CTS midway through the DATA bits of 0x3C → the frame completes, no further ReadEnable; raising CTS resumes.
- Reset mid-frame: assert Reset during bit 4 of 0x55.
  - Required: the next edge gives Tx=1, Busy=0, BytesSent=0.
  - Required: after release, the next byte is sent correctly.
- Counter wrap (COUNT_WIDTH=4): send 17 bytes → BytesSent goes 15→0→1.
